// File: rtl/regfile_wb.sv
// Integer register file for the Write Back / Decode stages: two bypassed read
// ports, one write port, x0 hardwired to zero, and a per-register load-pending scoreboard.
module regfile_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            wb_is_load,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_set_addr,
  input  logic            busy_clr,
  input  logic [AW-1:0]   busy_clr_addr,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wr_en;
  logic            ld_clr_en;

  assign wr_en     = we3 && (a3 != '0);
  assign ld_clr_en = wr_en && wb_is_load;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[a3] = wd3;
    regs_d[0] = '0;
  end

  // Clears are applied before the set so a same-address set always wins.
  always_comb begin
    busy_d = busy_q;
    if (busy_clr) busy_d[busy_clr_addr] = 1'b0;
    if (ld_clr_en) busy_d[a3] = 1'b0;
    if (busy_set && (busy_set_addr != '0)) busy_d[busy_set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if (!rst_n || (a == '0)) return '0;
    if (we3 && (a3 == a)) return wd3;
    return regs_q[a];
  endfunction

  // A load writing back this cycle already supplies its data via the bypass.
  function automatic logic busy_port(input logic [AW-1:0] a);
    if (!rst_n || (a == '0)) return 1'b0;
    if (ld_clr_en && (a3 == a)) return 1'b0;
    return busy_q[a];
  endfunction

  always_comb begin
    rd1      = read_port(a1);
    rd2      = read_port(a2);
    rs1_busy = busy_port(a1);
    rs2_busy = busy_port(a2);
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: a vector table applied one cycle per entry,
// plus a write-all / read-all sweep over the address space.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we3 = 1'b0;
  logic [4:0]  a3 = '0;
  logic [31:0] wd3 = '0;
  logic        wb_is_load = 1'b0;
  logic [4:0]  a1 = '0;
  logic [4:0]  a2 = '0;
  logic [31:0] rd1, rd2;
  logic        busy_set = 1'b0;
  logic [4:0]  busy_set_addr = '0;
  logic        busy_clr = 1'b0;
  logic [4:0]  busy_clr_addr = '0;
  logic        rs1_busy, rs2_busy;

  int checks = 0;
  int errors = 0;

  regfile_wb #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .we3(we3), .a3(a3), .wd3(wd3), .wb_is_load(wb_is_load),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .busy_set(busy_set), .busy_set_addr(busy_set_addr),
    .busy_clr(busy_clr), .busy_clr_addr(busy_clr_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, we3, ld;
    logic [4:0]  a3, a1, a2, bsa, bca;
    logic [31:0] wd3;
    logic        bs, bc;
    logic [31:0] e_rd1, e_rd2;
    logic        e_b1, e_b2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ld, input logic [4:0] ra1, input logic [4:0] ra2,
                     input logic bs, input logic [4:0] bsa, input logic bc, input logic [4:0] bca,
                     input logic [31:0] e1, input logic [31:0] e2, input logic eb1, input logic eb2);
    vec_t v;
    v.rst_n = r; v.we3 = w; v.a3 = wa; v.wd3 = wd; v.ld = ld; v.a1 = ra1; v.a2 = ra2;
    v.bs = bs; v.bsa = bsa; v.bc = bc; v.bca = bca;
    v.e_rd1 = e1; v.e_rd2 = e2; v.e_b1 = eb1; v.e_b2 = eb2;
    vecs.push_back(v);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle();
    we3 = 1'b0; a3 = '0; wd3 = '0; wb_is_load = 1'b0;
    busy_set = 1'b0; busy_set_addr = '0; busy_clr = 1'b0; busy_clr_addr = '0;
  endtask

  initial begin
    //  rst we a3  wd3           ld a1  a2  bs bsa bc bca  rd1           rd2          b1 b2
    add(0, 1, 5,  32'hFFFF_FFFF, 0, 5,  5,  1, 5, 0, 0,  32'h0,        32'h0,        0, 0);
    add(0, 1, 5,  32'hFFFF_FFFF, 0, 5,  5,  1, 5, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 5,  0,  0, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 1, 0,  32'h1234,      0, 0,  0,  0, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 1, 7,  32'hDEAD_BEEF, 0, 0,  0,  0, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 7,  7,  0, 0, 0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    add(1, 1, 3,  32'h11,        0, 7,  4,  0, 0, 0, 0,  32'hDEAD_BEEF, 32'h0,        0, 0);
    add(1, 1, 3,  32'h22,        0, 3,  4,  0, 0, 0, 0,  32'h22,       32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 3,  3,  0, 0, 0, 0,  32'h22,       32'h22,       0, 0);
    // load-use on x9
    add(1, 0, 0,  32'h0,         0, 9,  0,  1, 9, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 1, 9,  32'h99,        0, 9,  0,  0, 0, 0, 0,  32'h99,       32'h0,        1, 0);
    add(1, 0, 0,  32'h0,         0, 9,  0,  0, 0, 0, 0,  32'h99,       32'h0,        1, 0);
    add(1, 1, 9,  32'hAA,        1, 9,  0,  0, 0, 0, 0,  32'hAA,       32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 9,  0,  0, 0, 0, 0,  32'hAA,       32'h0,        0, 0);
    // flush / conflict on x12
    add(1, 0, 0,  32'h0,         0, 0,  12, 0, 0, 1, 12, 32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 0,  12, 1, 12, 0, 0, 32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 0,  12, 0, 0, 1, 12, 32'h0,        32'h0,        0, 1);
    add(1, 0, 0,  32'h0,         0, 0,  12, 1, 12, 1, 12, 32'h0,       32'h0,        0, 0);
    add(1, 1, 12, 32'hC,         1, 0,  12, 1, 12, 0, 0, 32'h0,        32'hC,        0, 0);
    add(1, 0, 0,  32'h0,         0, 0,  12, 1, 13, 1, 12, 32'h0,       32'hC,        0, 1);
    add(1, 0, 0,  32'h0,         0, 13, 12, 1, 0, 0, 0,  32'h0,        32'hC,        1, 0);
    add(1, 0, 0,  32'h0,         0, 0,  13, 0, 0, 0, 0,  32'h0,        32'h0,        0, 1);
    // reset mid-flight
    add(1, 1, 5,  32'hA5,        0, 0,  0,  1, 5, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 5,  0,  1, 6, 0, 0,  32'hA5,       32'h0,        1, 0);
    add(1, 0, 0,  32'h0,         0, 6,  5,  0, 0, 0, 0,  32'h0,        32'hA5,       1, 1);
    add(0, 1, 5,  32'h77,        0, 5,  6,  1, 5, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 5,  6,  0, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 7,  3,  0, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    add(1, 0, 0,  32'h0,         0, 12, 13, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; we3 = vecs[i].we3; a3 = vecs[i].a3; wd3 = vecs[i].wd3;
      wb_is_load = vecs[i].ld; a1 = vecs[i].a1; a2 = vecs[i].a2;
      busy_set = vecs[i].bs; busy_set_addr = vecs[i].bsa;
      busy_clr = vecs[i].bc; busy_clr_addr = vecs[i].bca;
      #1;
      chk32($sformatf("vec%0d rd1", i), rd1, vecs[i].e_rd1);
      chk32($sformatf("vec%0d rd2", i), rd2, vecs[i].e_rd2);
      chk1($sformatf("vec%0d rs1_busy", i), rs1_busy, vecs[i].e_b1);
      chk1($sformatf("vec%0d rs2_busy", i), rs2_busy, vecs[i].e_b2);
    end

    // Sweep: write a distinct value to every register and mark odd ones busy.
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      idle();
      we3 = 1'b1; a3 = 5'(r); wd3 = 32'h0101_0101 * r + 32'h5A;
      busy_set = r[0]; busy_set_addr = 5'(r);
    end
    @(negedge clk);
    idle();
    for (int r = 0; r < 32; r++) begin
      a1 = 5'(r); a2 = 5'(31 - r);
      #1;
      chk32($sformatf("sweep rd1 x%0d", r), rd1, (r == 0) ? 32'h0 : 32'h0101_0101 * r + 32'h5A);
      chk32($sformatf("sweep rd2 x%0d", 31 - r), rd2,
            (r == 31) ? 32'h0 : 32'h0101_0101 * (31 - r) + 32'h5A);
      chk1($sformatf("sweep rs1_busy x%0d", r), rs1_busy, (r % 2) == 1);
      chk1($sformatf("sweep rs2_busy x%0d", 31 - r), rs2_busy, ((31 - r) % 2) == 1);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
